// File: rtl/srio_pkg.sv
// Shared definitions for the SRIO receive-path blocks.
//   - HELLO header FTYPE/TTYPE code points and header field bit positions
//   - route_t: where a classified packet goes
//   - state_t: treq router packet-tracking states
//   - beat_t:  one AXI4-Stream beat payload (tdata/tkeep/tlast/tuser)
//   - classify(): header FTYPE/TTYPE -> route decision
package srio_pkg;

  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int USER_W = 32;

  // HELLO header field positions within the 64-bit header beat.
  localparam int TID_MSB   = 63;
  localparam int TID_LSB   = 56;
  localparam int FTYPE_MSB = 55;
  localparam int FTYPE_LSB = 52;
  localparam int TTYPE_MSB = 51;
  localparam int TTYPE_LSB = 48;
  localparam int SIZE_MSB  = 43;
  localparam int SIZE_LSB  = 36;
  localparam int ADDR_MSB  = 33;
  localparam int ADDR_LSB  = 0;

  localparam logic [3:0] FTYPE_DOORBELL = 4'hA;
  localparam logic [3:0] FTYPE_NWRITE   = 4'h5;
  localparam logic [3:0] FTYPE_SWRITE   = 4'h6;
  localparam logic [3:0] TTYPE_NWRITE   = 4'h4;
  localparam logic [3:0] TTYPE_NWRITE_R = 4'h5;

  typedef enum logic [1:0] {
    ROUTE_DB,
    ROUTE_NW,
    ROUTE_DROP
  } route_t;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_FWD_DB,
    ST_FWD_NW,
    ST_DROP
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [USER_W-1:0] user;
  } beat_t;

  // Header classification. The FTYPE code points are passed in so each
  // router instance can be retargeted through its parameters.
  function automatic route_t classify(input logic [3:0] ftype,
                                      input logic [3:0] ttype,
                                      input logic [3:0] db_ftype,
                                      input logic [3:0] nw_ftype,
                                      input logic [3:0] sw_ftype,
                                      input logic       route_sw);
    if (ftype == db_ftype)
      return ROUTE_DB;
    if ((ftype == nw_ftype) && ((ttype == TTYPE_NWRITE) || (ttype == TTYPE_NWRITE_R)))
      return ROUTE_NW;
    if ((ftype == sw_ftype) && route_sw)
      return ROUTE_NW;
    return ROUTE_DROP;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry AXI4-Stream register slice.
//   aclk, aresetn        : clock, asynchronous active-low reset
//   s_valid/s_ready/s_beat : upstream side; s_ready = slot empty or draining
//   m_valid/m_ready/m_beat : downstream side, fully registered
// Data is held stable while m_valid=1 and m_ready=0; m_valid only drops
// after a completed handshake.
module axis_reg_slice
  import srio_pkg::*;
(
  input  logic  aclk,
  input  logic  aresetn,
  input  logic  s_valid,
  output logic  s_ready,
  input  beat_t s_beat,
  output logic  m_valid,
  input  logic  m_ready,
  output beat_t m_beat
);

  assign s_ready = !m_valid || m_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid <= 1'b0;
      // NOTE: the payload register is reset too so the port shows zeros
      // out of reset; it is a single entry, not a memory array.
      m_beat  <= '0;
    end else if (s_valid && s_ready) begin
      m_valid <= 1'b1;
      m_beat  <= s_beat;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/srio_treq_router.sv
// SRIO treq router: classifies each HELLO-format packet on its header beat
// and forwards the whole packet to the doorbell port, the nwrite port, or
// discards it. Keeps saturating per-class packet counters.
//   aclk, aresetn            : clock, asynchronous active-low reset
//   s_axis_treq_*            : treq stream from the SRIO core
//   m_axis_db_*              : doorbell engine stream (registered)
//   m_axis_nw_*              : nwrite/swrite engine stream (registered)
//   db_cnt, nw_cnt, drop_cnt : saturating packet counters
//   drop_pulse               : one-cycle pulse per dropped packet
module srio_treq_router
  import srio_pkg::*;
#(
  parameter logic [3:0] C_DB_FTYPE     = FTYPE_DOORBELL,
  parameter logic [3:0] C_NW_FTYPE     = FTYPE_NWRITE,
  parameter logic [3:0] C_SW_FTYPE     = FTYPE_SWRITE,
  parameter bit         C_ROUTE_SWRITE = 1'b1,
  parameter int         C_CNT_W        = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               s_axis_treq_tvalid,
  output logic               s_axis_treq_tready,
  input  logic [63:0]        s_axis_treq_tdata,
  input  logic [7:0]         s_axis_treq_tkeep,
  input  logic               s_axis_treq_tlast,
  input  logic [31:0]        s_axis_treq_tuser,
  output logic               m_axis_db_tvalid,
  input  logic               m_axis_db_tready,
  output logic [63:0]        m_axis_db_tdata,
  output logic [7:0]         m_axis_db_tkeep,
  output logic               m_axis_db_tlast,
  output logic [31:0]        m_axis_db_tuser,
  output logic               m_axis_nw_tvalid,
  input  logic               m_axis_nw_tready,
  output logic [63:0]        m_axis_nw_tdata,
  output logic [7:0]         m_axis_nw_tkeep,
  output logic               m_axis_nw_tlast,
  output logic [31:0]        m_axis_nw_tuser,
  output logic [C_CNT_W-1:0] db_cnt,
  output logic [C_CNT_W-1:0] nw_cnt,
  output logic [C_CNT_W-1:0] drop_cnt,
  output logic               drop_pulse
);

  state_t state, next_state;
  route_t hdr_route, cur_route;
  beat_t  in_beat, db_beat, nw_beat;
  logic   run;
  logic   db_s_ready, nw_s_ready;
  logic   accept, hdr_accept, db_load, nw_load;

  assign in_beat = '{data: s_axis_treq_tdata, keep: s_axis_treq_tkeep,
                     last: s_axis_treq_tlast, user: s_axis_treq_tuser};

  assign hdr_route = classify(s_axis_treq_tdata[FTYPE_MSB:FTYPE_LSB],
                              s_axis_treq_tdata[TTYPE_MSB:TTYPE_LSB],
                              C_DB_FTYPE, C_NW_FTYPE, C_SW_FTYPE, C_ROUTE_SWRITE);

  // Holds tready low during reset and for the first cycle after release,
  // so no beat is taken before the FSM is known to be in HDR.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) run <= 1'b0;
    else          run <= 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_HDR;
    else          state <= next_state;
  end

  // NOTE: every signal assigned here gets a default first, so no path
  // through the case statements can infer a latch.
  always_comb begin
    next_state         = state;
    cur_route          = hdr_route;
    s_axis_treq_tready = 1'b0;

    case (state)
      ST_FWD_DB: cur_route = ROUTE_DB;
      ST_FWD_NW: cur_route = ROUTE_NW;
      ST_DROP:   cur_route = ROUTE_DROP;
      default:   cur_route = hdr_route;
    endcase

    // Only the slot this beat is headed for can stall the input; drops
    // never stall.
    case (cur_route)
      ROUTE_DB: s_axis_treq_tready = run && db_s_ready;
      ROUTE_NW: s_axis_treq_tready = run && nw_s_ready;
      default:  s_axis_treq_tready = run;
    endcase

    if (s_axis_treq_tvalid && s_axis_treq_tready) begin
      if (s_axis_treq_tlast) begin
        next_state = ST_HDR;
      end else if (state == ST_HDR) begin
        case (hdr_route)
          ROUTE_DB: next_state = ST_FWD_DB;
          ROUTE_NW: next_state = ST_FWD_NW;
          default:  next_state = ST_DROP;
        endcase
      end
    end
  end

  assign accept     = s_axis_treq_tvalid && s_axis_treq_tready;
  assign hdr_accept = accept && (state == ST_HDR);
  assign db_load    = accept && (cur_route == ROUTE_DB);
  assign nw_load    = accept && (cur_route == ROUTE_NW);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      db_cnt     <= '0;
      nw_cnt     <= '0;
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= hdr_accept && (hdr_route == ROUTE_DROP);
      if (hdr_accept) begin
        case (hdr_route)
          ROUTE_DB: if (db_cnt   != '1) db_cnt   <= db_cnt   + C_CNT_W'(1);
          ROUTE_NW: if (nw_cnt   != '1) nw_cnt   <= nw_cnt   + C_CNT_W'(1);
          default:  if (drop_cnt != '1) drop_cnt <= drop_cnt + C_CNT_W'(1);
        endcase
      end
    end
  end

  axis_reg_slice u_db_slice (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_valid (db_load),
    .s_ready (db_s_ready),
    .s_beat  (in_beat),
    .m_valid (m_axis_db_tvalid),
    .m_ready (m_axis_db_tready),
    .m_beat  (db_beat)
  );

  axis_reg_slice u_nw_slice (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_valid (nw_load),
    .s_ready (nw_s_ready),
    .s_beat  (in_beat),
    .m_valid (m_axis_nw_tvalid),
    .m_ready (m_axis_nw_tready),
    .m_beat  (nw_beat)
  );

  assign m_axis_db_tdata = db_beat.data;
  assign m_axis_db_tkeep = db_beat.keep;
  assign m_axis_db_tlast = db_beat.last;
  assign m_axis_db_tuser = db_beat.user;
  assign m_axis_nw_tdata = nw_beat.data;
  assign m_axis_nw_tkeep = nw_beat.keep;
  assign m_axis_nw_tlast = nw_beat.last;
  assign m_axis_nw_tuser = nw_beat.user;

endmodule

// File: doc/srio_treq_router.md
Name: srio_treq_router

Overview:
- Sits directly upstream of the doorbell and NWRITE receive engines in the SRIO receive path.
- Consumes the SRIO core's HELLO-format treq AXI4-Stream.
- Classifies each packet from its header beat and forwards the whole packet to exactly one engine port, or discards it.
- Replaces the shared-tvalid / OR'd-tready fan-out with one clean per-destination handshake, and keeps per-class packet counters.

Parameters:
- C_DB_FTYPE, 4'hA: FTYPE routed to the doorbell port.
- C_NW_FTYPE, 4'h5: FTYPE for NWRITE / NWRITE_R.
- C_SW_FTYPE, 4'h6: FTYPE for SWRITE.
- C_ROUTE_SWRITE, 1: 1 routes SWRITE to the nwrite port; 0 drops it.
- C_CNT_W, 16: width of the statistics counters.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_treq_tvalid/tready  in/out  1/1  treq from SRIO core
- s_axis_treq_tdata  in  64  beat data; header fields: TID[63:56], FTYPE[55:52], TTYPE[51:48], SIZE[43:36], ADDR[33:0]
- s_axis_treq_tkeep  in  8  byte enables
- s_axis_treq_tlast  in  1  end of packet
- s_axis_treq_tuser  in  32  {src_id, dest_id}
- m_axis_db_tvalid/tready  out/in  1/1  to doorbell engine
- m_axis_db_tdata/tkeep/tlast/tuser  out  64/8/1/32  doorbell packet beats
- m_axis_nw_tvalid/tready  out/in  1/1  to nwrite engine
- m_axis_nw_tdata/tkeep/tlast/tuser  out  64/8/1/32  nwrite/swrite packet beats
- db_cnt, nw_cnt, drop_cnt  out  C_CNT_W  saturating packet counters
- drop_pulse  out  1  one-cycle pulse per dropped packet

Behaviour:
- Reset (async assert, sync release): all tvalid=0, s_axis_treq_tready=0 while aresetn=0; counters=0; drop_pulse=0; FSM=HDR; output data registers=0.
- FSM states:
  - HDR: next accepted beat is a header.
  - FWD_DB: forwarding remaining beats to the doorbell port.
  - FWD_NW: forwarding remaining beats to the nwrite port.
  - DROP: consuming remaining beats without forwarding.
- Classification, on a header beat accepted in HDR:
  - FTYPE==C_DB_FTYPE -> DB.
  - FTYPE==C_NW_FTYPE and TTYPE in {4'h4, 4'h5} -> NW.
  - FTYPE==C_SW_FTYPE and C_ROUTE_SWRITE -> NW.
  - Everything else -> DROP.
- Header tlast=1 (single-beat packet): FSM stays in HDR. Otherwise it moves to FWD_DB / FWD_NW / DROP. Any beat with tlast=1 returns the FSM to HDR.
- Output stage: one registered slot per destination port. Latency is 1 cycle from input acceptance to m_*_tvalid.
- Throughput:
  - Forwarding: s_axis_treq_tready = !slot_valid[dest] || m_*_tready[dest], giving full throughput with no bubbles in steady state.
  - DROP state and dropped headers: tready=1 unconditionally.
- A slot holds its data stable while tvalid=1 and tready=0 (AXIS rule). tvalid never deasserts without a handshake.
- Only one destination slot is loaded per packet. The other port may still be draining a previous packet; both ports may be valid at the same cycle.
- Counters:
  - db_cnt / nw_cnt increment on acceptance of a routed header beat.
  - drop_cnt increments on acceptance of a dropped header beat; drop_pulse is asserted the following cycle.
  - All counters saturate at all-ones; no wrap.
- tkeep, tuser and tdata are passed through unmodified on every beat, header included.
- Reset asserted mid-packet: the FSM returns to HDR. The next beat after release is treated as a header (the core must also be reset).

Decomposition:
- Shared package srio_pkg:
  - FTYPE/TTYPE constants: FTYPE_DOORBELL=4'hA, FTYPE_NWRITE=4'h5, FTYPE_SWRITE=4'h6, TTYPE_NWRITE=4'h4, TTYPE_NWRITE_R=4'h5.
  - HELLO header field bit positions.
  - Route enum {ROUTE_DB, ROUTE_NW, ROUTE_DROP}.
- Sub-module axis_reg_slice (1-entry, 64/8/1/32 payload), instantiated once per destination port.

Test Plan:
- Doorbell header 0x01A0_0000_0000_1234, tlast=1, both readies=1 -> m_axis_db beat identical one cycle later; db_cnt=1; nw port idle.
- NWRITE header (FTYPE 5, TTYPE 4) plus 4 data beats, last beat tkeep=8'h0F -> 5 beats on nw port back-to-back, last beat tlast=1 with tkeep 0x0F; nw_cnt=1.
- Unsupported FTYPE 2 (NREAD) header plus 1 beat -> both beats accepted with tready=1 and nothing emitted; drop_cnt=1; drop_pulse high for exactly 1 cycle.
- Backpressure: m_axis_nw_tready low for 5 cycles mid-burst -> output data held stable; s_axis_treq_tready low; no beat lost or duplicated (scoreboard).
- C_ROUTE_SWRITE=0, SWRITE packet -> dropped; with C_ROUTE_SWRITE=1 the same packet -> nw port.
- Preload drop_cnt to 16'hFFFF via 65535 drops, then one more drop -> drop_cnt stays at 16'hFFFF.
- aresetn pulsed low mid NWRITE burst -> all tvalid=0 immediately; after release, the next beat is classified as a header.
